demux1_4_pipe: RTL and testbench
================================

Name: demux1_4_pipe

Overview:
- Registered 1-to-4 demultiplexer with valid/ready handshake; the write-side counterpart of the 4:1 select path.
- Routes one W-bit result per transfer from the execute stage to one of four sinks: 0 = register-file write port, 1 = store-data path, 2 = HI/LO unit, 3 = branch unit.
- A single output register stage sustains full throughput under back-pressure. A discard selection consumes a word without delivering it and counts it.

Parameters:
- W, 32, data width of in_data/out_data.
- CNT_W, 8, width of the saturating discard counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset. Assertion is asynchronous; deassertion is synchronised externally.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  W  upstream word.
- in_sel  input  3  bits[1:0] select sink 0..3; bit[2]=1 discards the word.
- out_valid  output  4  one-hot (or zero) valid per sink.
- out_ready  input  4  per-sink ready.
- out_data  output  W  held word, shared by all sinks.
- drop_cnt  output  CNT_W  number of discarded words, saturating.
- busy  output  1  output stage holds a word.

Behaviour:
- Reset (async, rst_n=0): state=EMPTY, out_valid=4'b0000, out_data=0, drop_cnt=0, busy=0, internal held selection=0. in_ready is 1 one cycle after deassertion; it is 0 while rst_n=0.
- Accept: a word is accepted on a rising edge where in_valid && in_ready. in_valid, in_data and in_sel must stay stable until accepted; the block does not check this.
- Deliver: a word is delivered on a rising edge where out_valid[k] && out_ready[k].
- FSM states EMPTY and FULL. Registers: data_q (W), sel_q (2).
  - EMPTY: in_ready=1. If an accepted word has in_sel[2]=0: data_q<=in_data, sel_q<=in_sel[1:0], go to FULL. If it has in_sel[2]=1: drop_cnt increments, stay EMPTY, data_q unchanged.
  - FULL: out_valid = one-hot(sel_q), out_data=data_q, busy=1. in_ready = out_ready[sel_q] (combinational).
    - Delivery with a simultaneous non-discard accept: load the new word, stay FULL. This gives zero bubble and 1 word/cycle.
    - Delivery with a discard accept: increment drop_cnt, go to EMPTY.
    - Delivery with no accept: go to EMPTY.
    - No delivery: hold all state; in_ready=0.
- Latency: accept at edge N, out_valid visible after edge N, deliverable at edge N+1 at the earliest.
- out_valid never has more than one bit set. out_ready bits of non-selected sinks are ignored.
- out_data is stable while out_valid is nonzero. In EMPTY it keeps the last delivered value (no X, no clear).
- drop_cnt saturates at 2^CNT_W-1. Discards continue to be accepted once saturated.
- A discard accept when FULL with no delivery cannot occur, because in_ready=0.
- No combinational path from in_valid to in_ready, or from in_data to out_*. The only combinational path is out_ready to in_ready.
- Reset mid-transfer: the held word is lost, out_valid drops immediately (async), and no partial delivery is reported.

Decomposition:
- Shared package demux_pkg holds:
  - sink encodings SINK_RF=2'd0, SINK_ST=2'd1, SINK_HILO=2'd2, SINK_BR=2'd3;
  - SEL_DISCARD_BIT=2;
  - a state enum with ST_EMPTY and ST_FULL.
- One sub-module: sat_counter, a CNT_W-bit saturating incrementer with async active-low reset, instantiated for drop_cnt.
- The one-hot expansion of sel_q stays inline.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0000, drop_cnt=0, in_ready=0. Release rst_n -> in_ready=1 on the next cycle.
- Single route: in_data=32'hDEADBEEF, in_sel=3'b010, out_ready=4'b1111 -> out_valid=4'b0100 one cycle later, out_data=DEADBEEF, then 0000 the cycle after.
- Back-pressure: sel=3, out_ready[3]=0 for 5 cycles -> in_ready=0 and out_valid=1000 with out_data stable for all 5 cycles. Raise out_ready[3] -> delivery, and a pending input is accepted in the same cycle.
- Streaming: 16 back-to-back words, sel cycling 0,1,2,3, all ready -> 16 deliveries in 17 cycles, in order, each on the correct one-hot lane.
- Discard: 300 words with in_sel=3'b100 -> out_valid stays 0000, drop_cnt=255 (saturated), in_ready=1 throughout. A FULL-state delivery coinciding with a discard returns the FSM to EMPTY.
- Async reset mid-transfer: FULL with sel=1 and out_ready=0, assert rst_n between edges -> out_valid=0000 immediately, busy=0, drop_cnt=0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared encodings for the 1-to-4 result demultiplexer: sink lanes, discard flag, FSM states.
package demux_pkg;

    localparam logic [1:0] SINK_RF   = 2'd0;
    localparam logic [1:0] SINK_ST   = 2'd1;
    localparam logic [1:0] SINK_HILO = 2'd2;
    localparam logic [1:0] SINK_BR   = 2'd3;

    localparam int SEL_DISCARD_BIT = 2;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/demux1_4_pipe_sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/demux1_4_pipe.sv
// Registered 1-to-4 result demultiplexer with valid/ready handshake and a discard counter.
// state    | meaning
// ST_EMPTY | no word held, upstream always ready
// ST_FULL  | word held in data_q, presented on lane sel_q
module demux1_4_pipe
    import demux_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [2:0]       in_sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [W-1:0]     out_data,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             busy
);

    state_t         state_q;
    logic [W-1:0]   data_q;
    logic [1:0]     sel_q;
    logic           rdy_en_q;
    logic           accept;
    logic           deliver;
    logic           discard;
    logic           load;

    // Keeps in_ready low during reset and for the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
        end
    end

    assign deliver  = (state_q == ST_FULL) && out_ready[sel_q];
    assign in_ready = rdy_en_q && ((state_q == ST_EMPTY) || out_ready[sel_q]);
    assign accept   = in_valid && in_ready;
    assign discard  = accept && in_sel[SEL_DISCARD_BIT];
    assign load     = accept && !in_sel[SEL_DISCARD_BIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            sel_q   <= 2'd0;
        end else if (load) begin
            state_q <= ST_FULL;
            data_q  <= in_data;
            sel_q   <= in_sel[1:0];
        end else if (deliver) begin
            state_q <= ST_EMPTY;
        end
    end

    always_comb begin
        out_valid = 4'b0000;
        if (state_q == ST_FULL) begin
            out_valid[sel_q] = 1'b1;
        end
    end

    assign out_data = data_q;
    assign busy     = (state_q == ST_FULL);

    sat_counter #(
        .W (CNT_W)
    ) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (discard),
        .count (drop_cnt)
    );

endmodule

// File: tb/tb_demux1_4_pipe.sv
// Directed-vector bench for demux1_4_pipe; inputs driven and outputs sampled on the falling edge.
module tb_demux1_4_pipe;

    localparam int W     = 32;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic [2:0]       in_sel;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [W-1:0]     out_data;
    logic [CNT_W-1:0] drop_cnt;
    logic             busy;

    int n_vec;
    int n_err;

    demux1_4_pipe #(
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every task starts and ends at a falling edge.
    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1234_5678;
        in_sel    = 3'b000;
        out_ready = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (out_valid !== 4'b0000) begin
            n_err++; $display("FAIL reset_out_valid got=%b exp=0000", out_valid);
        end
        n_vec++;
        if (drop_cnt !== 8'd0) begin
            n_err++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt);
        end
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_in_ready got=%b exp=0", in_ready);
        end
        n_vec++;
        if (busy !== 1'b0 || out_data !== 32'd0) begin
            n_err++; $display("FAIL reset_busy_data got=%b/%h exp=0/00000000", busy, out_data);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_single_route();
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        in_sel    = 3'b010;
        out_ready = 4'b1111;
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 4'b0100 || out_data !== 32'hDEAD_BEEF || busy !== 1'b1) begin
            n_err++; $display("FAIL single_present got=%b/%h/%b exp=0100/deadbeef/1", out_valid, out_data, busy);
        end
        @(negedge clk);
        n_vec++;
        if (out_valid !== 4'b0000 || busy !== 1'b0) begin
            n_err++; $display("FAIL single_drain got=%b/%b exp=0000/0", out_valid, busy);
        end
        n_vec++;
        if (out_data !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL single_hold_data got=%h exp=deadbeef", out_data);
        end
    endtask

    task automatic test_back_pressure();
        in_valid  = 1'b1;
        in_data   = 32'hA5A5_0003;
        in_sel    = 3'b011;
        out_ready = 4'b0111;
        @(negedge clk);
        in_data = 32'hB0B0_0001;
        in_sel  = 3'b001;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (in_ready !== 1'b0 || out_valid !== 4'b1000 || out_data !== 32'hA5A5_0003) begin
                n_err++;
                $display("FAIL backpressure_hold cyc=%0d got=%b/%b/%h exp=0/1000/a5a50003", i, in_ready, out_valid, out_data);
            end
            @(negedge clk);
        end
        out_ready = 4'b1111;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL backpressure_ready_comb got=%b exp=1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 4'b0010 || out_data !== 32'hB0B0_0001) begin
            n_err++; $display("FAIL backpressure_next_word got=%b/%h exp=0010/b0b00001", out_valid, out_data);
        end
        @(negedge clk);
        n_vec++;
        if (out_valid !== 4'b0000) begin
            n_err++; $display("FAIL backpressure_drain got=%b exp=0000", out_valid);
        end
    endtask

    task automatic test_streaming();
        logic [3:0]   exp_v;
        logic [W-1:0] exp_d;
        out_ready = 4'b1111;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) begin
                exp_v = 4'b0001 << ((k - 1) % 4);
                exp_d = 32'h1000_0000 + 32'(k - 1);
                n_vec++;
                if (out_valid !== exp_v || out_data !== exp_d) begin
                    n_err++; $display("FAIL stream_word%0d got=%b/%h exp=%b/%h", k - 1, out_valid, out_data, exp_v, exp_d);
                end
            end
            if (k < 16) begin
                in_valid = 1'b1;
                in_data  = 32'h1000_0000 + 32'(k);
                in_sel   = 3'(k % 4);
                n_vec++;
                if (in_ready !== 1'b1) begin
                    n_err++; $display("FAIL stream_in_ready%0d got=%b exp=1", k, in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        n_vec++;
        if (out_valid !== 4'b0000 || busy !== 1'b0) begin
            n_err++; $display("FAIL stream_end got=%b/%b exp=0000/0", out_valid, busy);
        end
    endtask

    task automatic test_discard();
        int bad;
        in_valid  = 1'b1;
        in_data   = 32'hC0DE_0000;
        in_sel    = 3'b000;
        out_ready = 4'b0000;
        @(negedge clk);
        in_data   = 32'hFFFF_FFFF;
        in_sel    = 3'b100;
        out_ready = 4'b0001;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 4'b0000 || busy !== 1'b0 || drop_cnt !== 8'd1) begin
            n_err++; $display("FAIL discard_with_delivery got=%b/%b/%0d exp=0000/0/1", out_valid, busy, drop_cnt);
        end
        n_vec++;
        if (out_data !== 32'hC0DE_0000) begin
            n_err++; $display("FAIL discard_data_untouched got=%h exp=c0de0000", out_data);
        end
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            in_data = 32'(i);
            if (in_ready !== 1'b1) bad++;
            @(negedge clk);
            if (out_valid !== 4'b0000) bad++;
            if (i == 99) begin
                n_vec++;
                if (drop_cnt !== 8'd101) begin
                    n_err++; $display("FAIL discard_count_mid got=%0d exp=101", drop_cnt);
                end
            end
        end
        in_valid = 1'b0;
        n_vec++;
        if (bad != 0) begin
            n_err++; $display("FAIL discard_stream_flags got=%0d bad cycles exp=0", bad);
        end
        n_vec++;
        if (drop_cnt !== 8'd255) begin
            n_err++; $display("FAIL discard_saturate got=%0d exp=255", drop_cnt);
        end
    endtask

    task automatic test_async_reset();
        in_valid  = 1'b1;
        in_data   = 32'h0BAD_F00D;
        in_sel    = 3'b001;
        out_ready = 4'b0000;
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 4'b0010 || busy !== 1'b1) begin
            n_err++; $display("FAIL async_pre_full got=%b/%b exp=0010/1", out_valid, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 4'b0000 || busy !== 1'b0 || drop_cnt !== 8'd0) begin
            n_err++; $display("FAIL async_reset_now got=%b/%b/%0d exp=0000/0/0", out_valid, busy, drop_cnt);
        end
        n_vec++;
        if (in_ready !== 1'b0 || out_data !== 32'd0) begin
            n_err++; $display("FAIL async_reset_ready_data got=%b/%h exp=0/00000000", in_ready, out_data);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (out_valid !== 4'b0000 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL async_recover got=%b/%b exp=0000/1", out_valid, in_ready);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single_route();
        test_back_pressure();
        test_streaming();
        test_discard();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
